apb_master: RTL and testbench
=============================

APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, address width of request and bus.
REQ-002 Parameter DATA_WIDTH, default 32, data width of request and bus.
REQ-003 Parameter TIMEOUT_CYCLES, default 255, maximum ACCESS cycles before abort (used only with APB_TIMEOUT_EN).
REQ-004 pclk  in  1  single clock; all state on rising edge.
REQ-005 presetn  in  1  asynchronous, active-low reset.
REQ-006 req_valid  in  1  core request present; req_ready  out  1  request accepted this cycle.
REQ-007 req_addr  in  ADDR_WIDTH; req_wdata  in  DATA_WIDTH; req_we  in  1; req_stb  in  4  byte strobes.
REQ-008 rsp_valid  out  1  one-cycle completion pulse; rsp_rdata  out  DATA_WIDTH; rsp_err  out  1.
REQ-009 paddr  out  ADDR_WIDTH; pdata  out  DATA_WIDTH  write data; pwrite  out  1; pstb  out  4.
REQ-010 psel  out  1; penable  out  1; prdata  in  DATA_WIDTH; ready  in  1; perr  in  1.

Function
REQ-011 FSM states IDLE, SETUP, ACCESS; one transfer in flight at a time.
REQ-012 req_ready SHALL be 1 exactly when state is IDLE; req_valid and req_ready both high at an edge = accept, registering addr/wdata/we/stb and moving to SETUP.
REQ-013 SETUP: psel=1, penable=0, lasting exactly one cycle, then ACCESS.
REQ-014 ACCESS: psel=1, penable=1; remains in ACCESS while ready=0 (wait states, unbounded unless REQ-024 applies).
REQ-015 paddr, pdata, pwrite, pstb SHALL be driven from the registered request and held constant from SETUP through the final ACCESS cycle.
REQ-016 ACCESS with ready=1 at an edge: capture prdata into rsp_rdata (reads; 0 for writes), capture perr into rsp_err, go to IDLE, assert rsp_valid for exactly the next cycle.
REQ-017 Latency with ready high in first ACCESS cycle: accept at edge 0, rsp_valid high in cycle following edge 2 (3 cycles accept-to-response).
REQ-018 IDLE: psel=0, penable=0, pwrite=0; paddr/pdata/pstb hold last values; at least one IDLE cycle between transfers (covers responders whose ready lags one cycle).
REQ-019 req_valid while not IDLE SHALL be ignored with no state change; the core holds it until accepted.
REQ-020 rsp_rdata and rsp_err SHALL hold their value until the next completion.
REQ-021 ready or perr while not in ACCESS SHALL be ignored.

Reset
REQ-022 presetn low SHALL immediately (asynchronously) force state IDLE and clear psel, penable, pwrite, rsp_valid, rsp_err, rsp_rdata, paddr, pdata, pstb and the timeout counter to 0; req_ready=1 after release.
REQ-023 Reset mid-transfer SHALL abandon the transfer with no rsp_valid produced.

Configuration
REQ-024 With APB_TIMEOUT_EN defined: counter cleared on entering ACCESS, incremented per ACCESS cycle without ready; on reaching TIMEOUT_CYCLES, go to IDLE, pulse rsp_valid with rsp_err=1 and rsp_rdata=0.
REQ-025 ready=1 on the same edge the counter reaches TIMEOUT_CYCLES SHALL complete normally (ready wins).
REQ-026 Without APB_TIMEOUT_EN: no counter logic; ACCESS waits indefinitely; TIMEOUT_CYCLES unused.

Verification
REQ-027 Write addr 0x10000000, wdata 0x00000041, stb 0x1, zero-wait responder -> SETUP then ACCESS, pwrite=1, pdata=0x41, rsp_valid 3 cycles after accept, rsp_err=0.
REQ-028 Read addr 0x10000005, responder returns 0x00000060 after 4 wait cycles -> psel/penable held 5 ACCESS cycles, rsp_rdata=0x60, rsp_valid single cycle.
REQ-029 Responder drives perr=1 with ready -> rsp_err=1; next transfer with perr=0 -> rsp_err=0.
REQ-030 req_valid held high continuously over 3 transfers -> exactly 3 accepts, one IDLE cycle between each psel pulse, no request dropped or duplicated.
REQ-031 presetn low during ACCESS -> psel/penable low before next edge, no rsp_valid, req_ready=1 after release.
REQ-032 APB_TIMEOUT_EN, TIMEOUT_CYCLES=8, ready never asserted -> rsp_valid with rsp_err=1, rsp_rdata=0 after 8 ACCESS cycles; ready on 8th cycle -> normal completion.

Source files
------------

// File: rtl/apb_master.sv
// ---------------------------------------------------------------------------
// apb_master
//
// Bridges a simple valid/ready core request onto an APB bus, one transfer at
// a time. Each transfer walks IDLE -> SETUP -> ACCESS (with wait states while
// the responder holds ready low) and finishes with a one-cycle rsp_valid
// pulse carrying the read data and the error flag.
//
// Optional feature (compile-time macro APB_TIMEOUT_EN):
//   When defined, an ACCESS phase that sees no ready for TIMEOUT_CYCLES
//   cycles is aborted and completes with rsp_err=1, rsp_rdata=0. When not
//   defined, ACCESS waits indefinitely and TIMEOUT_CYCLES has no effect.
//
// Ports
//   pclk, presetn          clock, asynchronous active-low reset
//   req_valid/req_ready    core request handshake (ready only in IDLE)
//   req_addr/req_wdata     request address and write data
//   req_we/req_stb         write enable and byte strobes
//   rsp_valid              one-cycle completion pulse
//   rsp_rdata/rsp_err      completion data/error, held until next completion
//   paddr/pdata/pwrite     APB address, write data, direction
//   pstb                   APB byte strobes
//   psel/penable           APB phase controls
//   prdata/ready/perr      APB responder read data, ready and error
// ---------------------------------------------------------------------------
module apb_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  pclk,
    input  logic                  presetn,

    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic                  req_we,
    input  logic [3:0]            req_stb,

    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,

    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0] pdata,
    output logic                  pwrite,
    output logic [3:0]            pstb,
    output logic                  psel,
    output logic                  penable,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  ready,
    input  logic                  perr
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    logic [1:0]            state_q,     state_d;
    logic [ADDR_WIDTH-1:0] paddr_q,     paddr_d;
    logic [DATA_WIDTH-1:0] pdata_q,     pdata_d;
    logic                  we_q,        we_d;
    logic [3:0]            pstb_q,      pstb_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q,   rsp_err_d;

`ifdef APB_TIMEOUT_EN
    localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    // The abort fires on the edge where the count would reach TIMEOUT_CYCLES.
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
`endif

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before the case so that no path
        // leaves it unassigned; otherwise synthesis would infer a latch.
        state_d     = state_q;
        paddr_d     = paddr_q;
        pdata_d     = pdata_q;
        we_d        = we_q;
        pstb_d      = pstb_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
`ifdef APB_TIMEOUT_EN
        tmo_cnt_d   = tmo_cnt_q;
`endif

        case (state_q)
            ST_IDLE: begin
                // req_ready is high throughout IDLE, so req_valid alone
                // completes the handshake here.
                if (req_valid) begin
                    paddr_d = req_addr;
                    pdata_d = req_wdata;
                    we_d    = req_we;
                    pstb_d  = req_stb;
                    state_d = ST_SETUP;
                end
            end

            ST_SETUP: begin
                state_d = ST_ACCESS;
`ifdef APB_TIMEOUT_EN
                tmo_cnt_d = '0;
`endif
            end

            ST_ACCESS: begin
                // ready takes priority over the timeout when both coincide.
                if (ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = we_q ? '0 : prdata;
                    rsp_err_d   = perr;
                end
`ifdef APB_TIMEOUT_EN
                else if (tmo_cnt_q == TMO_LAST) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
                end
`endif
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q     <= ST_IDLE;
            paddr_q     <= '0;
            pdata_q     <= '0;
            we_q        <= 1'b0;
            pstb_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
`ifdef APB_TIMEOUT_EN
            tmo_cnt_q   <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling the
            // pre-edge values, independent of statement order.
            state_q     <= state_d;
            paddr_q     <= paddr_d;
            pdata_q     <= pdata_d;
            we_q        <= we_d;
            pstb_q      <= pstb_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
`ifdef APB_TIMEOUT_EN
            tmo_cnt_q   <= tmo_cnt_d;
`endif
        end
    end

    // -----------------------------------------------------------------------
    // Outputs: all decoded from registers, so reset clears them at once.
    // -----------------------------------------------------------------------
    assign req_ready = (state_q == ST_IDLE);
    assign psel      = (state_q != ST_IDLE);
    assign penable   = (state_q == ST_ACCESS);
    // The registered direction is kept for the response path; the bus only
    // shows it while a transfer is in progress.
    assign pwrite    = we_q && (state_q != ST_IDLE);
    assign paddr     = paddr_q;
    assign pdata     = pdata_q;
    assign pstb      = pstb_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master.sv
// ---------------------------------------------------------------------------
// tb_apb_master
//
// Directed scoreboard bench for apb_master. The driver pushes the expected
// bus transfer and response into queues at accept time; a bus monitor and a
// response monitor pop and compare independently. A small responder model
// inserts a programmed number of wait states and returns programmed data.
// Build with APB_TIMEOUT_EN defined to add the timeout cases.
// ---------------------------------------------------------------------------
module tb_apb_master;

    localparam int TMO = 8;

    logic        pclk = 1'b0;
    logic        presetn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        req_we = 1'b0;
    logic [3:0]  req_stb = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] paddr;
    logic [31:0] pdata;
    logic        pwrite;
    logic [3:0]  pstb;
    logic        psel;
    logic        penable;
    logic [31:0] prdata = '0;
    logic        ready = 1'b0;
    logic        perr = 1'b0;

    apb_master #(
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .pclk     (pclk),
        .presetn  (presetn),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .req_we   (req_we),
        .req_stb  (req_stb),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .paddr    (paddr),
        .pdata    (pdata),
        .pwrite   (pwrite),
        .pstb     (pstb),
        .psel     (psel),
        .penable  (penable),
        .prdata   (prdata),
        .ready    (ready),
        .perr     (perr)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        logic [3:0]  stb;
        int          acc;       // expected number of ACCESS cycles
        logic [31:0] rdata;     // expected rsp_rdata
        logic        err;       // expected rsp_err
        int          acc_edge;  // clock edge at which the request is accepted
    } exp_t;

    exp_t bus_q[$];
    exp_t rsp_q[$];

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int dut_accepts = 0;
    int issued = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Edge counter plus an independent count of handshakes seen by the DUT.
    always @(posedge pclk) begin
        cyc++;
        if (presetn && req_valid && req_ready) dut_accepts++;
    end

    // -----------------------------------------------------------------------
    // Responder: ready after cfg_waits wait cycles of ACCESS. With cfg_noise
    // it also drives ready/perr high outside ACCESS, which must be ignored.
    // -----------------------------------------------------------------------
    int          cfg_waits = 0;
    logic [31:0] cfg_data = '0;
    logic        cfg_perr = 1'b0;
    logic        cfg_noise = 1'b0;
    int          acc_cnt = 0;

    always @(negedge pclk) begin
        if (psel && penable) begin
            ready  = (acc_cnt == cfg_waits);
            perr   = ready ? cfg_perr : cfg_noise;
            prdata = ready ? cfg_data : 32'hBAD0_BAD0;
            acc_cnt++;
        end else begin
            ready  = cfg_noise;
            perr   = cfg_noise;
            prdata = 32'hBAD0_BAD0;
            acc_cnt = 0;
        end
    end

    // -----------------------------------------------------------------------
    // Bus monitor
    // -----------------------------------------------------------------------
    exp_t cur;
    logic in_x = 1'b0;
    int   acc_n = 0;

    always @(negedge pclk) begin
        if (!presetn) begin
            in_x  = 1'b0;
            acc_n = 0;
        end else if (psel && !penable) begin
            check("idle_before_setup", 32'(in_x), 32'd0);
            if (bus_q.size() == 0) begin
                fail_now("unexpected_setup");
                in_x = 1'b0;
            end else begin
                cur = bus_q.pop_front();
                in_x  = 1'b1;
                acc_n = 0;
                check("setup_paddr", paddr, cur.addr);
                check("setup_pdata", pdata, cur.wdata);
                check("setup_pwrite", 32'(pwrite), 32'(cur.we));
                check("setup_pstb", 32'(pstb), 32'(cur.stb));
            end
        end else if (psel && penable) begin
            acc_n++;
            if (in_x)
                check("access_stable",
                      32'({paddr == cur.addr, pdata == cur.wdata,
                           pwrite == cur.we, pstb == cur.stb}), 32'hF);
        end else begin
            if (in_x) begin
                check("access_cycles", 32'(acc_n), 32'(cur.acc));
                in_x = 1'b0;
            end
            check("idle_pwrite_penable", 32'({pwrite, penable}), 32'd0);
        end
    end

    // -----------------------------------------------------------------------
    // Response monitor
    // -----------------------------------------------------------------------
    logic [31:0] last_rdata = '0;
    logic        last_err = 1'b0;
    logic        prev_valid = 1'b0;

    always @(negedge pclk) begin
        exp_t e;
        if (!presetn) begin
            last_rdata = '0;
            last_err   = 1'b0;
            prev_valid = 1'b0;
        end else begin
            if (rsp_valid) begin
                check("rsp_pulse_width", 32'(prev_valid), 32'd0);
                if (rsp_q.size() == 0) begin
                    fail_now("unexpected_rsp");
                end else begin
                    e = rsp_q.pop_front();
                    check("rsp_rdata", rsp_rdata, e.rdata);
                    check("rsp_err", 32'(rsp_err), 32'(e.err));
                    check("rsp_latency", 32'(cyc - e.acc_edge), 32'(e.acc + 1));
                end
                last_rdata = rsp_rdata;
                last_err   = rsp_err;
            end else begin
                check("rsp_hold", 32'({rsp_err, rsp_rdata[30:0]}),
                      32'({last_err, last_rdata[30:0]}));
            end
            prev_valid = rsp_valid;
        end
    end

    // -----------------------------------------------------------------------
    // Driver. Called at a negedge; presents the request, waits for req_ready,
    // pushes expectations and returns at the negedge after the accept edge
    // with req_valid still high.
    // -----------------------------------------------------------------------
    task automatic issue(input logic [31:0] addr, input logic [31:0] wdata,
                         input logic we, input logic [3:0] stb, input int waits,
                         input logic [31:0] rdata, input logic rperr);
        exp_t e;
        bit   got;
        req_addr  = addr;
        req_wdata = wdata;
        req_we    = we;
        req_stb   = stb;
        req_valid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (req_ready) begin
                got = 1'b1;
                break;
            end
            @(negedge pclk);
        end
        if (!got) begin
            fail_now("accept_timeout");
            req_valid = 1'b0;
            return;
        end
        cfg_waits = waits;
        cfg_data  = rdata;
        cfg_perr  = rperr;
        e.addr     = addr;
        e.wdata    = wdata;
        e.we       = we;
        e.stb      = stb;
        e.acc      = waits + 1;
        e.rdata    = we ? 32'd0 : rdata;
        e.err      = rperr;
        e.acc_edge = cyc + 1;
`ifdef APB_TIMEOUT_EN
        if (waits >= TMO) begin
            e.acc   = TMO;
            e.rdata = 32'd0;
            e.err   = 1'b1;
        end
`endif
        bus_q.push_back(e);
        rsp_q.push_back(e);
        issued++;
        @(negedge pclk);
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) @(negedge pclk);
    endtask

    task automatic drain();
        bit done;
        req_valid = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (rsp_q.size() == 0 && req_ready) begin
                done = 1'b1;
                break;
            end
            @(negedge pclk);
        end
        if (!done) fail_now("drain_timeout");
        @(negedge pclk);
    endtask

    // -----------------------------------------------------------------------
    // Stimulus
    // -----------------------------------------------------------------------
    initial begin
        repeat (3) @(negedge pclk);
        check("rst_psel", 32'(psel), 32'd0);
        check("rst_penable", 32'(penable), 32'd0);
        check("rst_pwrite", 32'(pwrite), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_paddr", paddr, 32'd0);
        check("rst_pdata", pdata, 32'd0);
        check("rst_pstb", 32'(pstb), 32'd0);
        presetn = 1'b1;
        @(negedge pclk);
        check("rst_req_ready", 32'(req_ready), 32'd1);

        // Zero-wait write; write responses return rdata 0.
        issue(32'h1000_0000, 32'h0000_0041, 1'b1, 4'h1, 0, 32'hDEAD_BEEF, 1'b0);
        check("setup_req_ready", 32'(req_ready), 32'd0);
        drain();

        // Read with four wait states; responder noise outside ACCESS.
        cfg_noise = 1'b1;
        issue(32'h1000_0005, 32'h0, 1'b0, 4'hF, 4, 32'h0000_0060, 1'b0);
        drain();
        cfg_noise = 1'b0;

        // Error response, then a clean one.
        issue(32'h2000_0010, 32'h0, 1'b0, 4'hF, 1, 32'h1234_5678, 1'b1);
        drain();
        issue(32'h2000_0014, 32'h5555_AAAA, 1'b1, 4'h3, 0, 32'h0, 1'b0);
        drain();

        // Three requests with req_valid held high throughout.
        issue(32'h3000_0000, 32'hCAFE_0001, 1'b1, 4'hF, 0, 32'h0, 1'b0);
        issue(32'h3000_0004, 32'h0, 1'b0, 4'hF, 2, 32'hA5A5_0002, 1'b0);
        issue(32'h3000_0008, 32'h0, 1'b0, 4'hC, 0, 32'h0000_0077, 1'b1);
        drain();
        check("b2b_accepts", 32'(dut_accepts), 32'(issued));

        // Reset during ACCESS abandons the transfer.
        issue(32'h4000_0000, 32'h0, 1'b0, 4'hF, 20, 32'h1111_1111, 1'b0);
        req_valid = 1'b0;
        @(negedge pclk);
        check("pre_rst_penable", 32'(penable), 32'd1);
        #2 presetn = 1'b0;
        #1;
        check("async_rst_psel", 32'(psel), 32'd0);
        check("async_rst_penable", 32'(penable), 32'd0);
        rsp_q.delete();
        bus_q.delete();
        repeat (2) @(negedge pclk);
        presetn = 1'b1;
        check("post_rst_req_ready", 32'(req_ready), 32'd1);
        check("post_rst_rsp_rdata", rsp_rdata, 32'd0);
        check("post_rst_rsp_err", 32'(rsp_err), 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge pclk);
            check("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
        end

        // Normal operation after reset.
        issue(32'h5000_0020, 32'h0, 1'b0, 4'hF, 1, 32'hFEED_F00D, 1'b0);
        drain();

`ifdef APB_TIMEOUT_EN
        // Ready never comes: abort after TMO ACCESS cycles.
        issue(32'h6000_0000, 32'h0, 1'b0, 4'hF, 1000, 32'h9999_9999, 1'b0);
        drain();
        // Ready on the last allowed cycle: normal completion.
        issue(32'h6000_0004, 32'h0, 1'b0, 4'hF, TMO - 1, 32'h0000_00AB, 1'b0);
        drain();
`endif

        check("total_accepts", 32'(dut_accepts), 32'(issued));
        check("bus_q_empty", 32'(bus_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global safety net.
    initial begin
        #200000;
        $display("FAIL global_timeout (cycle %0d)", cyc);
        $fatal(1, "simulation time limit reached");
    end

endmodule
